rr_arbiter_4way: RTL and testbench
==================================

# rr_arbiter_4way

Round-robin arbiter that shares one 16-bit write path among four requesters. It issues a registered one-hot grant and the matching 2-bit `sel` code. The same `sel` drives the DMux4Way/Mux4Way16 routing in the memory section, so exactly one requester owns the path in any cycle. A hold-limit counter stops any single owner from monopolising the path.

## Interface
- `WIDTH`, 16, data width of each requester's word.
- `MAX_HOLD`, 8, maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..255.

- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `req`  in  4  request bit per requester; bit i = requester i.
- `data_in`  in  4*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  4  registered one-hot grant, or all zero.
- `sel`  out  2  registered binary index of the current owner; drives the demux select.
- `busy`  out  1  registered; high when `gnt` is non-zero.
- `data_out`  out  WIDTH  combinational: `data_in` word at index `sel` when `busy`, else 0.

## Operation
- State:
  - `owner` (2 b) is presented on `sel`.
  - `busy` (1 b).
  - `hold_cnt` (8 b) counts the current owner's consecutive granted cycles, starting at 0.
  - `last` (2 b) is the round-robin pointer.
- Two logical states:
  - IDLE: `busy` = 0.
  - GRANT: `busy` = 1.
- Arbitration happens only at a rising edge.
  - Search order starts at (last+1) mod 4 and wraps, covering all four indices.
  - The previous owner is therefore checked last.
- IDLE transitions:
  - If any `req` bit is high, grant the first requester in search order. Set `owner` and `last` to that index, set `busy` = 1 and `hold_cnt` = 0.
  - Otherwise stay in IDLE.
- GRANT transitions, evaluated in priority order:
  1. Owner's `req` is low (release): arbitrate among the remaining requesters in search order. A winner gets the grant with `hold_cnt` = 0. With no winner, go to IDLE; `sel` keeps its value and `gnt` = 0.
  2. Owner's `req` is high and `hold_cnt` = MAX_HOLD-1 (timeout): arbitrate in search order. A different winner takes the grant. If the owner is the only requester, it is re-granted with `hold_cnt` = 0.
  3. Otherwise the owner keeps the grant and `hold_cnt` increments.
- `gnt` = one-hot decode of `owner` when `busy`, else 4'b0000. It is never multi-hot.
- `hold_cnt` never exceeds MAX_HOLD-1, so no wrap-around is possible.
- Reset state:
  - `gnt` = 0000, `sel` = 00, `busy` = 0, `data_out` = 0.
  - `hold_cnt` = 0, `last` = 3, so requester 0 has first priority after reset.
- Reset mid-grant: the grant is dropped on that edge regardless of `req`. Arbitration resumes on the first edge with `reset` low.

## Timing
- Grant latency: a `req` first sampled high at edge N (path idle) gives `gnt` high after edge N; 1-cycle latency.
- Release latency: the owner's `req` sampled low at edge N gives its `gnt` low after edge N.
  - A waiting requester's `gnt` rises after that same edge N, with no bubble cycle.
- Maximum continuous ownership with contention: MAX_HOLD cycles. The handover appears after the edge where `hold_cnt` = MAX_HOLD-1.
- Worst-case wait for a continuously requesting input: 3*MAX_HOLD + 1 cycles.
- `data_out` follows `sel`/`busy` combinationally, so it is valid in the same cycle as `gnt`.
- Simultaneous release and new requests on one edge: the release rule applies and arbitration considers only the other requesters' `req` values at that edge.

## Test plan
- Reset: hold `reset` = 1 for 2 cycles with `req` = 1111 → `gnt` = 0000, `sel` = 00, `busy` = 0, `data_out` = 0. Release reset → after the next edge, `gnt` = 0001.
- Single requester: `req` = 0100 steady, MAX_HOLD = 8, for 20 cycles → `gnt` = 0100 and `sel` = 10 in every cycle, including re-grants at timeout. `data_out` equals word 2 (e.g. 16'hBEEF).
- Rotation under full load: `req` = 1111 for 40 cycles, MAX_HOLD = 8 → grant order 0001, 0010, 0100, 1000, 0001, each held exactly 8 cycles.
- Release handover: owner 1 drops `req` at edge N while `req[3]` is high → `gnt` = 1000 and `sel` = 11 after edge N, with no idle cycle between grants.
- Pointer fairness: owner 0 releases, then `req` = 0101 → grant goes to 2, not 0. After 2 releases, with `req` = 0001 → grant goes to 0.
- Reset mid-grant: assert `reset` while `gnt` = 0010 mid-hold → `gnt` = 0000 after that edge. After reset is released with `req` = 0010 → `gnt` = 0010 one edge later with `hold_cnt` restarted, verified by a full 8-cycle hold against a contending `req[3]`.

Source files
------------

// File: rtl/rr_arbiter_4way_if.sv
// Bus bundle between four requesters and the round-robin write-path arbiter.
interface rr_arbiter_4way_if #(
  parameter int unsigned WIDTH = 16
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data_in;
  logic [3:0]         gnt;
  logic [1:0]         sel;
  logic               busy;
  logic [WIDTH-1:0]   data_out;

  // Requester side: raises requests and supplies words, observes grant and routed data.
  modport master (
    output req, data_in,
    input  gnt, sel, busy, data_out
  );

  // Arbiter side.
  modport slave (
    input  req, data_in,
    output gnt, sel, busy, data_out
  );
endinterface

// File: rtl/rr_arbiter_4way.sv
// Four-way round-robin arbiter for a shared WIDTH-bit write path, with a
// hold limit so no single owner keeps the path for more than MAX_HOLD
// consecutive cycles while others wait.
module rr_arbiter_4way #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  rr_arbiter_4way_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] owner;
  logic [1:0] last;
  logic [7:0] hold_cnt;
  logic [3:0] gnt_q;
  logic       busy_q;

  logic [1:0] win;
  logic       found;
  logic [1:0] idx;

  // Search requesters starting just after the pointer; the pointer itself
  // (the current owner while granted) is visited last. A released owner has
  // its req low, so it drops out of the search without extra masking.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Grant state machine with registered grant, select and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= 2'd3;
      hold_cnt <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            owner    <= win;
            last     <= win;
            hold_cnt <= '0;
            gnt_q    <= 4'(1) << win;
            busy_q   <= 1'b1;
          end
        end
        GRANT: begin
          if (!bus.req[owner] || hold_cnt == HOLD_LAST) begin
            if (found) begin
              owner    <= win;
              last     <= win;
              hold_cnt <= '0;
              gnt_q    <= 4'(1) << win;
            end else begin
              state    <= IDLE;
              hold_cnt <= '0;
              gnt_q    <= '0;
              busy_q   <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = owner;
  assign bus.busy = busy_q;

  // Route the owner's word onto the shared path; zero while idle.
  always_comb begin
    bus.data_out = '0;
    if (busy_q) begin
      bus.data_out = bus.data_in[32'(owner) * WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4way.sv
// Self-checking bench for rr_arbiter_4way: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_rr_arbiter_4way;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned MAX_HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   m_busy, m_owner, m_last, m_run;

  rr_arbiter_4way_if #(.WIDTH(WIDTH)) bus ();

  rr_arbiter_4way #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_gnt();
    return m_busy ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [WIDTH-1:0] exp_data();
    logic [4*WIDTH-1:0] d;
    d = bus.data_in;
    return m_busy ? d[m_owner*WIDTH +: WIDTH] : '0;
  endfunction

  // First requester scanning (last+1), (last+2), ... wrapping mod 4; -1 if none.
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  task automatic model_update(input logic [3:0] r, input logic rst);
    int p;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 3; m_run = 0;
    end else if (!m_busy || !r[m_owner] || m_run == MAX_HOLD) begin
      p = pick(r);
      if (p >= 0) begin
        m_busy = 1; m_owner = p; m_last = p; m_run = 1;
      end else begin
        m_busy = 0; m_run = 0;
      end
    end else begin
      m_run = m_run + 1;
    end
  endtask

  // Advance one clock, update the model with the sampled inputs, settle.
  task automatic tick();
    logic [3:0] r;
    logic       rs;
    @(posedge clk);
    r  = bus.req;
    rs = reset;
    model_update(r, rs);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = 4'b1111;
    tick(); tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", bus.gnt); end
    checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b want 00", bus.sel); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.data_out !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", bus.data_out); end
    reset = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", bus.gnt); end
  endtask

  task automatic test_single();
    do_reset();
    bus.data_in = {16'h1234, 16'hBEEF, 16'h5678, 16'h9ABC};
    bus.req = 4'b0100;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt t=%0d got %b want 0100", t, bus.gnt); end
      checks++; if (bus.sel !== 2'b10) begin errors++; $display("FAIL single_sel t=%0d got %b want 10", t, bus.sel); end
      checks++; if (bus.data_out !== 16'hBEEF) begin errors++; $display("FAIL single_data t=%0d got %h want beef", t, bus.data_out); end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    bus.req = 4'b1111;
    for (int t = 0; t < 40; t++) begin
      tick();
      want = 4'(1 << ((t / MAX_HOLD) % 4));
      checks++; if (bus.gnt !== want) begin errors++; $display("FAIL rotation t=%0d got %b want %b", t, bus.gnt, want); end
      checks++; if (bus.data_out !== exp_data()) begin errors++; $display("FAIL rotation_data t=%0d got %h want %h", t, bus.data_out, exp_data()); end
    end
  endtask

  task automatic test_release();
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b1010;
    tick(); tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL release_pre got %b want 0010", bus.gnt); end
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL release_gnt got %b want 1000", bus.gnt); end
    checks++; if (bus.sel !== 2'b11) begin errors++; $display("FAIL release_sel got %b want 11", bus.sel); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL release_busy got %b want 1", bus.busy); end
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req = 4'b0001; tick();
    bus.req = 4'b0000; tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL fair_idle got %b want 0000", bus.gnt); end
    bus.req = 4'b0101; tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL fair_skip0 got %b want 0100", bus.gnt); end
    bus.req = 4'b0000; tick();
    bus.req = 4'b0001; tick();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL fair_back0 got %b want 0001", bus.gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b0010;
    tick(); tick(); tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_pre got %b want 0010", bus.gnt); end
    reset = 1'b1; tick();
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL midrst_drop got %b want 0000", bus.gnt); end
    reset = 1'b0; tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_regrant got %b want 0010", bus.gnt); end
    bus.req = 4'b1010;
    for (int t = 1; t < MAX_HOLD; t++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL midrst_hold t=%0d got %b want 0010", t, bus.gnt); end
    end
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL midrst_handover got %b want 1000", bus.gnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      bus.req     = 4'($urandom_range(0, 15));
      bus.data_in = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      reset       = ($urandom_range(0, 63) == 0);
      tick();
      // Re-randomize data after the edge to exercise the combinational read path.
      bus.data_in = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      checks++; if (bus.gnt !== exp_gnt()) begin errors++; $display("FAIL rand_gnt t=%0d got %b want %b", t, bus.gnt, exp_gnt()); end
      checks++; if (bus.sel !== 2'(m_owner)) begin errors++; $display("FAIL rand_sel t=%0d got %0d want %0d", t, bus.sel, m_owner); end
      checks++; if (bus.busy !== 1'(m_busy)) begin errors++; $display("FAIL rand_busy t=%0d got %b want %0d", t, bus.busy, m_busy); end
      checks++; if (bus.data_out !== exp_data()) begin errors++; $display("FAIL rand_data t=%0d got %h want %h", t, bus.data_out, exp_data()); end
      checks++; if (!$onehot0(bus.gnt)) begin errors++; $display("FAIL rand_onehot t=%0d got %b want one-hot or zero", t, bus.gnt); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.data_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    m_busy = 0; m_owner = 0; m_last = 3; m_run = 0;
    test_reset();
    test_single();
    test_rotation();
    test_release();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
